// File: rtl/axis_pkt_len_guard.sv
// AXI-Stream packet length guard: truncates over-long packets, flags runts and
// FIFO overflows in m_tuser, and keeps saturating statistics.
module axis_pkt_len_guard #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MAX_WORDS  = 64,
    parameter int unsigned MIN_WORDS  = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic [DATA_BYTES*8-1:0] s_tdata,
    input  logic [DATA_BYTES-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    in_overflow,
    output logic [DATA_BYTES*8-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    output logic                    m_tuser,
    input  logic                    m_tready,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    trunc_cnt,
    output logic [CNT_WIDTH-1:0]    runt_cnt,
    output logic [CNT_WIDTH-1:0]    ovf_cnt
);

    localparam int unsigned         DW          = DATA_BYTES * 8;
    localparam logic [15:0]          LP_LAST_IDX = 16'(MAX_WORDS - 1);
    localparam logic [16:0]          LP_MIN      = 17'(MIN_WORDS);
    localparam logic [15:0]          LP_WC_MAX   = 16'hFFFF;
    localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX  = '1;

    typedef enum logic {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t                r_state;
    logic [15:0]           r_word_cnt;
    logic                  r_err;
    logic [DW-1:0]         r_m_tdata;
    logic [DATA_BYTES-1:0] r_m_tkeep;
    logic                  r_m_tlast;
    logic                  r_m_tvalid;
    logic                  r_m_tuser;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_trunc_cnt;
    logic [CNT_WIDTH-1:0]  r_runt_cnt;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;

    logic w_out_free;
    logic w_accept;
    logic w_fwd;
    logic w_trunc;
    logic w_runt;
    logic w_fwd_last;
    logic w_err_now;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == LP_CNT_MAX) ? c : c + CNT_WIDTH'(1);
    endfunction

    // Drops in DISCARD never wait on the output register.
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s_tready   = (r_state == ST_DISCARD) || w_out_free;
    assign w_accept   = s_tvalid && s_tready;
    assign w_fwd      = w_accept && (r_state == ST_PASS);
    assign w_trunc    = w_fwd && (r_word_cnt == LP_LAST_IDX) && !s_tlast;
    assign w_runt     = w_fwd && s_tlast && (({1'b0, r_word_cnt} + 17'd1) < LP_MIN);
    assign w_fwd_last = w_fwd && (s_tlast || w_trunc);
    // An overflow coinciding with the closing beat belongs to that packet.
    assign w_err_now  = r_err || in_overflow;

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state     <= ST_PASS;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tlast   <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
            r_runt_cnt  <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (w_out_free) begin
                r_m_tvalid <= w_fwd;
                if (w_fwd) begin
                    r_m_tdata <= s_tdata;
                    r_m_tkeep <= s_tkeep;
                    r_m_tlast <= s_tlast || w_trunc;
                    r_m_tuser <= w_fwd_last && (w_trunc || w_runt || w_err_now);
                end
            end

            r_err <= w_fwd_last ? 1'b0 : w_err_now;

            if (w_accept) begin
                if (s_tlast) begin
                    r_word_cnt <= '0;
                end else if (r_word_cnt != LP_WC_MAX) begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                end
            end

            case (r_state)
                ST_PASS: begin
                    if (w_trunc) begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_accept && s_tlast) begin
                        r_state <= ST_PASS;
                    end
                end
                default: r_state <= ST_PASS;
            endcase

            if (w_fwd_last) begin
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end
            if (w_trunc) begin
                r_trunc_cnt <= sat_inc(r_trunc_cnt);
            end
            if (w_runt) begin
                r_runt_cnt <= sat_inc(r_runt_cnt);
            end
            if (in_overflow) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
        end
    end

    assign m_tdata   = r_m_tdata;
    assign m_tkeep   = r_m_tkeep;
    assign m_tlast   = r_m_tlast;
    assign m_tvalid  = r_m_tvalid;
    assign m_tuser   = r_m_tuser;
    assign pkt_cnt   = r_pkt_cnt;
    assign trunc_cnt = r_trunc_cnt;
    assign runt_cnt  = r_runt_cnt;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_axis_pkt_len_guard.sv
// Directed and randomized-ready bench for axis_pkt_len_guard with MAX_WORDS=4,
// MIN_WORDS=3 and 4-bit counters so saturation is reachable.
module tb_axis_pkt_len_guard;

    localparam int unsigned DB  = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned MAXW = 4;
    localparam int unsigned MINW = 3;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic          clk;
    logic          sreset;
    logic [15:0]   s_tdata;
    logic [1:0]    s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic          in_overflow;
    logic [15:0]   m_tdata;
    logic [1:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tuser;
    logic          m_tready;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] trunc_cnt;
    logic [CW-1:0] runt_cnt;
    logic [CW-1:0] ovf_cnt;

    int    n_checks = 0;
    int    n_errors = 0;
    logic  rand_mode = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t out_q[$];
    beat_t exp_q[$];
    int    stalls;

    axis_pkt_len_guard #(
        .DATA_BYTES(DB),
        .MAX_WORDS (MAXW),
        .MIN_WORDS (MINW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .sreset     (sreset),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .in_overflow(in_overflow),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tuser    (m_tuser),
        .m_tready   (m_tready),
        .pkt_cnt    (pkt_cnt),
        .trunc_cnt  (trunc_cnt),
        .runt_cnt   (runt_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at every falling edge: stall stability, tuser rule, beat capture.
    task automatic monitor();
        beat_t cur;
        cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
        if (sreset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_tvalid), 32'd1);
                check("stall_beat", 32'(cur), 32'(prev_beat));
            end
            if (m_tvalid && !m_tlast) check("nonlast_tuser", 32'(m_tuser), 32'd0);
            if (m_tvalid && m_tready) out_q.push_back(cur);
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = cur;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        in_overflow = 1'b0;
        if (rand_mode) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l,
                        input logic ovf, output int n_stall);
        logic acc;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1; in_overflow = ovf;
        n_stall = 0;
        acc = 1'b0;
        while (!acc && n_stall < 500) begin
            @(negedge clk);
            monitor();
            acc = s_tready;
            @(posedge clk);
            #1;
            in_overflow = 1'b0;
            if (rand_mode) m_tready = 1'($urandom_range(0, 1));
            if (!acc) n_stall++;
        end
        s_tvalid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [1:0] k, input logic l, input logic u);
        exp_q.push_back('{data: d, keep: k, last: l, user: u});
    endtask

    task automatic compare_out(input string tag);
        int n;
        repeat (5) tick();
        check({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, 32'(out_q[i]), 32'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cnts(input string tag, input int p, input int t, input int r, input int o);
        check({tag, "_pkt_cnt"},   32'(pkt_cnt),   32'(p));
        check({tag, "_trunc_cnt"}, 32'(trunc_cnt), 32'(t));
        check({tag, "_runt_cnt"},  32'(runt_cnt),  32'(r));
        check({tag, "_ovf_cnt"},   32'(ovf_cnt),   32'(o));
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    initial begin
        int e_pkt, e_trunc, e_runt, len;
        logic [15:0] d;
        logic [1:0]  k;
        logic        l, el, eu;

        sreset = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        in_overflow = 1'b0; m_tready = 1'b1;

        // Reset values while sreset is held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_tlast),  32'd0);
        check("rst_m_tuser",  32'(m_tuser),  32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        check_cnts("rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        sreset = 1'b0;

        // Exactly MAX_WORDS beats ending in tlast passes untouched
        for (int i = 1; i <= 4; i++) begin
            send(16'h1000 + 16'(i), 2'b11, 1'(i == 4), 1'b0, stalls);
            push_exp(16'h1000 + 16'(i), 2'b11, 1'(i == 4), 1'b0);
        end
        compare_out("max_len");
        check_cnts("max_len", 1, 0, 0, 0);

        // 7-beat packet: truncated at beat 4, rest dropped while output is stalled
        for (int i = 1; i <= 4; i++) begin
            send(16'h2000 + 16'(i), 2'b01, 1'b0, 1'b0, stalls);
            push_exp(16'h2000 + 16'(i), 2'b01, 1'(i == 4), 1'(i == 4));
        end
        m_tready = 1'b0;
        for (int i = 5; i <= 7; i++) begin
            send(16'h2000 + 16'(i), 2'b01, 1'(i == 7), 1'b0, stalls);
            check("discard_no_stall", 32'(stalls), 32'd0);
        end
        m_tready = 1'b1;
        compare_out("trunc");
        check_cnts("trunc", 2, 1, 0, 0);

        for (int i = 1; i <= 3; i++) begin
            send(16'h3000 + 16'(i), 2'b10, 1'(i == 3), 1'b0, stalls);
            push_exp(16'h3000 + 16'(i), 2'b10, 1'(i == 3), 1'b0);
        end
        compare_out("after_trunc");
        check_cnts("after_trunc", 3, 1, 0, 0);

        // Runt: 2 beats with MIN_WORDS=3
        send(16'h4001, 2'b11, 1'b0, 1'b0, stalls);
        send(16'h4002, 2'b11, 1'b1, 1'b0, stalls);
        push_exp(16'h4001, 2'b11, 1'b0, 1'b0);
        push_exp(16'h4002, 2'b11, 1'b1, 1'b1);
        compare_out("runt");
        check_cnts("runt", 4, 1, 1, 0);

        // Overflow on beat 2 flags beat 3; following packet is clean
        for (int i = 1; i <= 3; i++) begin
            send(16'h5000 + 16'(i), 2'b11, 1'(i == 3), 1'(i == 2), stalls);
            push_exp(16'h5000 + 16'(i), 2'b11, 1'(i == 3), 1'(i == 3));
        end
        for (int i = 1; i <= 3; i++) begin
            send(16'h6000 + 16'(i), 2'b11, 1'(i == 3), 1'b0, stalls);
            push_exp(16'h6000 + 16'(i), 2'b11, 1'(i == 3), 1'b0);
        end
        compare_out("ovf");
        check_cnts("ovf", 6, 1, 1, 1);

        // Overflow coincident with the tlast beat applies to that packet
        for (int i = 1; i <= 3; i++) begin
            send(16'h7000 + 16'(i), 2'b11, 1'(i == 3), 1'(i == 3), stalls);
            push_exp(16'h7000 + 16'(i), 2'b11, 1'(i == 3), 1'(i == 3));
        end
        compare_out("ovf_last");
        check_cnts("ovf_last", 7, 1, 1, 2);

        // Reset mid truncated packet with the truncating beat still buffered
        for (int i = 1; i <= 4; i++) begin
            send(16'h8000 + 16'(i), 2'b11, 1'b0, 1'b0, stalls);
            if (i < 4) push_exp(16'h8000 + 16'(i), 2'b11, 1'b0, 1'b0);
        end
        m_tready = 1'b0;
        send(16'h8005, 2'b11, 1'b0, 1'b0, stalls);
        sreset = 1'b1;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_m_tlast",  32'(m_tlast),  32'd0);
        check("mid_rst_m_tuser",  32'(m_tuser),  32'd0);
        check("mid_rst_s_tready", 32'(s_tready), 32'd1);
        check_cnts("mid_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        compare_out("pre_rst");
        for (int i = 1; i <= 4; i++) begin
            send(16'h9000 + 16'(i), 2'b01, 1'(i == 4), 1'b0, stalls);
            push_exp(16'h9000 + 16'(i), 2'b01, 1'(i == 4), 1'b0);
        end
        compare_out("post_rst");
        check_cnts("post_rst", 1, 0, 0, 0);

        // 1000 packets of 1..6 beats under random backpressure
        e_pkt = 1; e_trunc = 0; e_runt = 0;
        rand_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                d = 16'($urandom);
                k = 2'($urandom);
                l = (i == len - 1);
                send(d, k, l, 1'b0, stalls);
                if (i < 4) begin
                    el = l || (i == 3);
                    eu = ((i == 3) && (len > 4)) || (l && (len < 3));
                    push_exp(d, k, el, eu);
                end
            end
            e_pkt = sat(e_pkt);
            if (len > 4) e_trunc = sat(e_trunc);
            if (len < 3) e_runt = sat(e_runt);
        end
        rand_mode = 1'b0;
        m_tready = 1'b1;
        compare_out("random");
        check_cnts("random", e_pkt, e_trunc, e_runt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
